// File: rtl/layer_pkg.sv
// Shared types and defaults for the LED serial line encoder.
package layer_pkg;

    localparam int unsigned PIX_W_DEF   = 24;
    localparam logic [15:0] RST_CYC_DEF = 16'd5000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_e;

endpackage

// File: rtl/layer_code_bit.sv
// Per-bit timer: latches the high/period counts on start, then walks one bit period.
module layer_code_bit (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start_in,
    input  logic [7:0] high_cnt_in,
    input  logic [7:0] period_cnt_in,
    output logic       level_out,
    output logic       end_out
);

    logic [7:0] high_q;
    logic [7:0] period_q;
    logic [7:0] cnt_q;

    // Counts are held for the whole bit so mid-bit input changes are ignored.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            high_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
        end else if (start_in) begin
            high_q   <= high_cnt_in;
            period_q <= period_cnt_in;
            cnt_q    <= '0;
        end else if (cnt_q != period_q) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_comb begin
        level_out = (cnt_q <= high_q);
        end_out   = (cnt_q == period_q);
    end

endmodule

// File: rtl/layer_code.sv
// LED serial line encoder: streams pixels MSB first as timed pulses, then a frame latch.
module layer_code
    import layer_pkg::*;
#(
    parameter logic [15:0] RST_CYC = RST_CYC_DEF,
    parameter int unsigned PIX_W   = PIX_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [7:0]       t0h_cnt_in,
    input  logic [7:0]       t0s_cnt_in,
    input  logic [7:0]       t1h_cnt_in,
    input  logic [7:0]       t1s_cnt_in,
    input  logic             pix_vld_in,
    input  logic [PIX_W-1:0] pix_data_in,
    input  logic             pix_last_in,
    output logic             pix_rdy_out,
    output logic             bit_code_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int unsigned IDX_W = $clog2(PIX_W);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PIX_W - 1);

    state_e           state_q, state_d;
    logic [PIX_W-2:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic [15:0]      latch_q, latch_d;
    logic             done_q, done_d;

    logic       bit_level;
    logic       bit_end;
    logic       bit_start;
    logic       next_bit;
    logic       pix_end;
    logic       xfer;
    logic [7:0] sel_high;
    logic [7:0] sel_period;

    always_comb begin
        pix_end     = (state_q == SEND) && bit_end && (idx_q == '0);
        // Ready in the final cycle of a non-last pixel lets the next one follow with no gap.
        pix_rdy_out = !rst_in && ((state_q == IDLE) || (pix_end && !last_q));
        xfer        = pix_vld_in && pix_rdy_out;
        bit_start   = xfer || ((state_q == SEND) && bit_end && (idx_q != '0));
        next_bit    = xfer ? pix_data_in[PIX_W-1] : shift_q[PIX_W-2];
        sel_high    = next_bit ? t1h_cnt_in : t0h_cnt_in;
        sel_period  = next_bit ? t1s_cnt_in : t0s_cnt_in;
    end

    layer_code_bit u_bit (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_in      (bit_start),
        .high_cnt_in   (sel_high),
        .period_cnt_in (sel_period),
        .level_out     (bit_level),
        .end_out       (bit_end)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        last_d  = last_q;
        latch_d = latch_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = SEND;
                    shift_d = pix_data_in[PIX_W-2:0];
                    last_d  = pix_last_in;
                    idx_d   = IDX_MAX;
                end
            end
            SEND: begin
                if (bit_end) begin
                    if (idx_q != '0) begin
                        idx_d   = idx_q - IDX_W'(1);
                        shift_d = shift_q << 1;
                    end else if (last_q) begin
                        state_d = LATCH;
                        latch_d = '0;
                    end else if (xfer) begin
                        shift_d = pix_data_in[PIX_W-2:0];
                        last_d  = pix_last_in;
                        idx_d   = IDX_MAX;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LATCH: begin
                if (latch_q == RST_CYC - 16'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    latch_d = latch_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            latch_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            latch_q <= latch_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        bit_code_out = (state_q == SEND) && bit_level;
        busy_out     = (state_q != IDLE);
        done_out     = done_q;
    end

endmodule

// File: tb/tb_layer_code.sv
// Directed bench for layer_code: waveform shapes, back-to-back, latch, reset abort.
module tb_layer_code;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  t0h, t0s, t1h, t1s;
    logic        vld, last;
    logic [23:0] data;
    logic        rdy, line, busy, done;

    int n_vec = 0;
    int n_err = 0;
    logic wave[$];
    logic expw[$];

    always #5 clk = ~clk;

    layer_code dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .t0h_cnt_in   (t0h),
        .t0s_cnt_in   (t0s),
        .t1h_cnt_in   (t1h),
        .t1s_cnt_in   (t1s),
        .pix_vld_in   (vld),
        .pix_data_in  (data),
        .pix_last_in  (last),
        .pix_rdy_out  (rdy),
        .bit_code_out (line),
        .busy_out     (busy),
        .done_out     (done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic exp_bit(input int h, input int s);
        for (int c = 0; c <= s; c++) expw.push_back(c <= h);
    endtask

    task automatic exp_pix(input logic [23:0] px);
        for (int b = 23; b >= 0; b--) begin
            if (px[b]) exp_bit(int'(t1h), int'(t1s));
            else       exp_bit(int'(t0h), int'(t0s));
        end
    endtask

    // Samples the line for n cycles; valid drops after the first sample.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wave.push_back(line);
            if (i == 0) vld = 1'b0;
        end
    endtask

    task automatic compare_wave(input string tag);
        int diffs = 0;
        int n;
        check({tag, "_len"}, wave.size(), expw.size());
        n = (wave.size() < expw.size()) ? wave.size() : expw.size();
        for (int i = 0; i < n; i++) if (wave[i] !== expw[i]) diffs++;
        check(tag, diffs, 0);
        wave.delete();
        expw.delete();
    endtask

    task automatic send(input logic [23:0] px, input logic l);
        vld  = 1'b1;
        data = px;
        last = l;
    endtask

    task automatic set_counts(input logic [7:0] a, b, c, d);
        t0h = a; t0s = b; t1h = c; t1s = d;
    endtask

    initial begin
        int hi, rd, dn, bz;
        rst = 1'b1; vld = 1'b0; last = 1'b0; data = '0;
        set_counts(8'd1, 8'd4, 8'd3, 8'd4);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_line", line, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdy", rdy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", rdy, 1);

        // Single pixel then underrun
        send(24'h800000, 1'b0);
        capture(120);
        check("latency1", wave[0], 1);
        exp_bit(3, 4);
        for (int i = 0; i < 23; i++) exp_bit(1, 4);
        compare_wave("single_pix");
        @(negedge clk);
        check("underrun_busy", busy, 0);
        check("underrun_line", line, 0);
        check("underrun_rdy", rdy, 1);

        // Two pixels back to back, second last, then latch
        send(24'hA50F3C, 1'b0);
        for (int i = 0; i < 240; i++) begin
            @(negedge clk);
            wave.push_back(line);
            if (i == 0) begin data = 24'h3CC35A; last = 1'b1; end
            if (i == 119) check("rdy_b2b", rdy, 1);
            if (i == 120) vld = 1'b0;
        end
        exp_pix(24'hA50F3C);
        exp_pix(24'h3CC35A);
        compare_wave("b2b");
        hi = 0; rd = 0; dn = 0; bz = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            hi += int'(line); rd += int'(rdy); dn += int'(done); bz += int'(busy);
        end
        check("latch_line", hi, 0);
        check("latch_rdy", rd, 0);
        check("latch_done", dn, 0);
        check("latch_busy", bz, 5000);
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_rdy", rdy, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        // One-cycle periods and high-time 0
        set_counts(8'd0, 8'd1, 8'd0, 8'd0);
        send(24'hF0F0F0, 1'b0);
        capture(36);
        exp_pix(24'hF0F0F0);
        compare_wave("short_bits");
        @(negedge clk);
        check("short_idle", busy, 0);

        // High time beyond period keeps the line high
        set_counts(8'd1, 8'd4, 8'd9, 8'd4);
        send(24'hFFFFFF, 1'b0);
        capture(120);
        hi = 0;
        foreach (wave[i]) hi += int'(wave[i]);
        check("all_high_cnt", hi, 120);
        exp_pix(24'hFFFFFF);
        compare_wave("all_high");
        @(negedge clk);
        check("all_high_idle_line", line, 0);

        // Period change mid-bit only affects later bits
        set_counts(8'd1, 8'd4, 8'd3, 8'd4);
        send(24'h000000, 1'b0);
        for (int i = 0; i < 189; i++) begin
            @(negedge clk);
            wave.push_back(line);
            if (i == 0) vld = 1'b0;
            if (i == 2) t0s = 8'd7;
        end
        exp_bit(1, 4);
        for (int i = 0; i < 23; i++) exp_bit(1, 7);
        compare_wave("midbit_change");
        @(negedge clk);
        check("midbit_idle", busy, 0);

        // Reset during latch aborts with no done pulse
        set_counts(8'd1, 8'd4, 8'd3, 8'd4);
        send(24'h800000, 1'b1);
        capture(120);
        exp_pix(24'h800000);
        compare_wave("pre_abort");
        repeat (1000) @(negedge clk);
        check("abort_in_latch", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_line", line, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rdy", rdy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_rdy_release", rdy, 1);
        dn = 0; bz = 0;
        for (int i = 0; i < 4200; i++) begin
            @(negedge clk);
            dn += int'(done); bz += int'(busy);
        end
        check("abort_no_done", dn, 0);
        check("abort_stays_idle", bz, 0);

        // Valid held during latch is not accepted until idle
        send(24'h123456, 1'b1);
        capture(120);
        exp_pix(24'h123456);
        compare_wave("pre_hold");
        send(24'hC00000, 1'b0);
        rd = 0; bz = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            rd += int'(rdy); bz += int'(busy);
        end
        check("hold_rdy", rd, 0);
        check("hold_busy", bz, 5000);
        @(negedge clk);
        check("hold_done", done, 1);
        check("hold_rdy_idle", rdy, 1);
        capture(120);
        exp_pix(24'hC00000);
        compare_wave("after_hold");
        @(negedge clk);
        check("after_hold_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
